ysyx_25040111_regfile_sb: RTL and testbench
===========================================

# ysyx_25040111_regfile_sb

Parametrised integer register file with an integrated write-back scoreboard and a sequential clear engine, the next generation of the core's register file. It serves the decode/issue stage: two combinational read ports with write-through forwarding, one write-back port, and one reservation port. Issue marks a destination as pending; write-back clears it. The block reports read-after-write hazards so decode can stall multi-cycle producers such as loads and mul/div.

## Interface
- XLEN, 32, data width in bits
- NREG, 16, register count, power of two, at least 2; NREG=16 is RV32E, NREG=32 is RV32I
- AW, $clog2(NREG), address width (derived, not overridden)

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high; starts the clear sweep
- ready  out  1  high when the clear sweep is finished and the file is operational
- wen  in  1  write-back enable
- waddr  in  AW  write-back address
- wdata  in  XLEN  write-back data
- rsv_en  in  1  reservation enable (issue of an instruction with a destination register)
- rsv_addr  in  AW  destination to mark pending
- ren  in  2  read enables; bit0 is rs1, bit1 is rs2
- ars1, ars2  in  AW  read addresses
- rs1, rs2  out  XLEN  read data
- hazard  out  1  an enabled read targets a pending register that is not being written back this cycle
- pend_cnt  out  AW+1  number of registers currently pending

## Operation
- State machine has two states, CLEAR and RUN.
  - Reset, sampled high at a posedge, enters CLEAR with sweep index 0 and zeroes all pend bits.
  - CLEAR writes 0 to rf[index] each cycle, then increments the index. After writing index NREG-1 the block moves to RUN.
  - RUN persists until the next reset.
- ready is 1 only in RUN.
- In CLEAR:
  - wen and rsv_en are ignored.
  - rs1 and rs2 read 0.
  - hazard is 0.
- Write in RUN: if wen and waddr != 0, then rf[waddr] <= wdata and pend[waddr] <= 0.
- Reserve in RUN: if rsv_en and rsv_addr != 0, then pend[rsv_addr] <= 1.
  - If the write and the reservation hit the same address in the same cycle, the reservation wins and pend stays 1. This is the new producer.
  - Writes to address 0 are discarded. Reservations of address 0 are discarded.
- Read, port k (combinational):
  - If ren[k]=0, or ars_k=0, or the state is CLEAR, the port reads 0.
  - Else if wen and waddr == ars_k, the port reads wdata (forwarding).
  - Otherwise the port reads rf[ars_k].
  - The x0 check is independent of storage contents.
- hazard = OR over k of (ren[k] and ars_k != 0 and pend[ars_k] and not (wen and waddr == ars_k)).
  - Same-cycle write-back therefore resolves the hazard.
  - A same-cycle reservation does not affect hazard until the next cycle.
- pend_cnt is a registered count of set pend bits, updated in the same cycle as the pend bits.
  - Net change per cycle is -1, 0 or +1.
  - It never exceeds NREG-1, since x0 is never pending.

## Timing
- Reset values, in the cycle after reset is sampled:
  - ready=0, hazard=0, pend_cnt=0, rs1=rs2=0
  - all pend bits 0, sweep index 0
- Clear latency: exactly NREG cycles from the first CLEAR cycle. ready rises on the posedge that completes the write of index NREG-1.
- Reset asserted mid-sweep restarts the sweep at index 0. Reset asserted in RUN discards all pending state.
- Read data, hazard and forwarding are combinational in the same cycle. A write becomes visible from storage the cycle after the posedge.
- A reservation issued at cycle t produces hazard for matching reads from cycle t+1.

## Test plan
- Clear:
  - Preload rf with nonzero values, then assert reset for 1 cycle.
  - ready must stay 0 for exactly NREG=16 cycles.
  - After ready, every ars read returns 0 and pend_cnt=0.
- Forwarding:
  - RUN, wen=1, waddr=5, wdata=0xDEADBEEF, ren=2'b11, ars1=ars2=5.
  - Same cycle: rs1=rs2=0xDEADBEEF.
  - Next cycle with wen=0: both still read 0xDEADBEEF.
- x0:
  - wen=1, waddr=0, wdata=0x1234 with ars1=0: rs1=0.
  - rsv_en with rsv_addr=0: pend_cnt unchanged.
  - rs2 reading x0 never raises hazard.
- Scoreboard:
  - Reserve x7 at cycle t: pend_cnt=1 at t+1, and ars1=7 with ren=01 gives hazard=1.
  - Write-back x7 with 0x55 at t+3: hazard=0 that cycle, rs1=0x55, pend_cnt=0 at t+4.
- Simultaneous events:
  - In one cycle: wen to x3, rsv_en to x3, with pend[3]=1 beforehand. pend[3] stays 1 and pend_cnt is unchanged.
  - In one cycle: wen to x4 (pending), rsv_en to x9. pend_cnt is unchanged, hazard follows x9 next cycle.
- Mid-sweep reset and ignored traffic:
  - Assert reset again at sweep cycle 6. ready rises 16 cycles after the second reset.
  - wen and rsv_en driven during CLEAR leave storage at 0 and pend_cnt at 0.

Source files
------------

// File: rtl/ysyx_25040111_regfile_sb_if.sv
// Bus between decode/issue and the scoreboarded register file.
//   master : issue side, drives write-back, reservation and read requests
//   slave  : register file, returns read data, hazard, pending count, ready
interface ysyx_25040111_regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 16
) ();
    localparam int AW = $clog2(NREG);

    logic            ready;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic [1:0]      ren;
    logic [AW-1:0]   ars1;
    logic [AW-1:0]   ars2;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            hazard;
    logic [AW:0]     pend_cnt;

    modport master (
        output wen, waddr, wdata, rsv_en, rsv_addr, ren, ars1, ars2,
        input  ready, rs1, rs2, hazard, pend_cnt
    );

    modport slave (
        input  wen, waddr, wdata, rsv_en, rsv_addr, ren, ars1, ars2,
        output ready, rs1, rs2, hazard, pend_cnt
    );
endinterface

// File: rtl/ysyx_25040111_regfile_sb.sv
// Integer register file with write-back scoreboard and sequential clear.
//   clock  : single clock, all state on posedge
//   reset  : synchronous active-high, restarts the clear sweep
//   bus    : slave side of ysyx_25040111_regfile_sb_if
//            wen/waddr/wdata  write-back port
//            rsv_en/rsv_addr  reservation (marks destination pending)
//            ren/ars1/ars2    read requests, rs1/rs2 combinational data
//            hazard           enabled read hits an unresolved pending reg
//            pend_cnt         registered number of pending registers
//            ready            high once the clear sweep has completed
module ysyx_25040111_regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 16
) (
    input logic                       clock,
    input logic                       reset,
    ysyx_25040111_regfile_sb_if.slave bus
);
    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            run, wr_do, rsv_do, cnt_inc, cnt_dec;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(NREG - 1)) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    assign run    = (state_q == RUN);
    assign wr_do  = run && bus.wen    && (bus.waddr    != '0);
    assign rsv_do = run && bus.rsv_en && (bus.rsv_addr != '0);

    // Storage has no reset; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == CLEAR) rf[idx_q] <= '0;
            else if (wr_do)       rf[bus.waddr] <= bus.wdata;
        end
    end

    // Reservation is applied after the write-back clear so a same-address
    // collision leaves the bit set for the new producer.
    always_comb begin
        pend_d = pend_q;
        if (wr_do)  pend_d[bus.waddr]    = 1'b0;
        if (rsv_do) pend_d[bus.rsv_addr] = 1'b1;
    end

    // Count tracks pend_d incrementally instead of a popcount.
    assign cnt_inc = rsv_do && !pend_q[bus.rsv_addr];
    assign cnt_dec = wr_do && pend_q[bus.waddr]
                     && !(rsv_do && (bus.rsv_addr == bus.waddr));

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec)      cnt_d = cnt_q + 1'b1;
        else if (cnt_dec && !cnt_inc) cnt_d = cnt_q - 1'b1;
    end

    function automatic logic [XLEN-1:0] read_port(input logic en, input logic [AW-1:0] a);
        if (!en || (a == '0) || !run)    return '0;
        if (bus.wen && (bus.waddr == a)) return bus.wdata;
        return rf[a];
    endfunction

    function automatic logic port_hazard(input logic en, input logic [AW-1:0] a);
        return en && (a != '0) && pend_q[a] && !(bus.wen && (bus.waddr == a));
    endfunction

    always_comb begin
        bus.rs1    = read_port(bus.ren[0], bus.ars1);
        bus.rs2    = read_port(bus.ren[1], bus.ars2);
        bus.hazard = run && (port_hazard(bus.ren[0], bus.ars1) ||
                             port_hazard(bus.ren[1], bus.ars2));
    end

    assign bus.ready    = run;
    assign bus.pend_cnt = cnt_q;
endmodule

// File: tb/tb_ysyx_25040111_regfile_sb.sv
module tb_ysyx_25040111_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ysyx_25040111_regfile_sb_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

    ysyx_25040111_regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural state only.
    bit          m_valid = 0;
    bit          m_clear;
    int          m_sweep;
    logic [31:0] m_rf   [NREG];
    bit          m_pend [NREG];

    function automatic logic [31:0] exp_rd(input logic en, input logic [3:0] a);
        if (!en || a == 0 || m_clear) return 32'h0;
        if (bus.wen && bus.waddr == a) return bus.wdata;
        return m_rf[a];
    endfunction

    function automatic logic exp_hz(input logic en, input logic [3:0] a);
        if (m_clear || !en || a == 0) return 1'b0;
        return m_pend[a] && !(bus.wen && bus.waddr == a);
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += m_pend[i];
        return n;
    endfunction

    // Inputs change at posedge+1, so at negedge they hold the values the
    // next posedge will sample: check outputs, then advance the model.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("ready",    {31'b0, bus.ready},  {31'b0, !m_clear});
            chk("rs1",      bus.rs1,             exp_rd(bus.ren[0], bus.ars1));
            chk("rs2",      bus.rs2,             exp_rd(bus.ren[1], bus.ars2));
            chk("hazard",   {31'b0, bus.hazard}, {31'b0, exp_hz(bus.ren[0], bus.ars1) | exp_hz(bus.ren[1], bus.ars2)});
            chk("pend_cnt", {27'b0, bus.pend_cnt}, 32'(exp_cnt()));
        end
        if (reset) begin
            m_valid = 1;
            m_clear = 1;
            m_sweep = 0;
            for (int i = 0; i < NREG; i++) m_pend[i] = 0;
        end else if (m_valid) begin
            if (m_clear) begin
                m_rf[m_sweep] = 32'h0;
                m_sweep++;
                if (m_sweep == NREG) m_clear = 0;
            end else begin
                if (bus.wen && bus.waddr != 0) begin
                    m_rf[bus.waddr]   = bus.wdata;
                    m_pend[bus.waddr] = 0;
                end
                if (bus.rsv_en && bus.rsv_addr != 0) m_pend[bus.rsv_addr] = 1;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.wen = 0; bus.waddr = '0; bus.wdata = '0;
        bus.rsv_en = 0; bus.rsv_addr = '0;
        bus.ren = 2'b00; bus.ars1 = '0; bus.ars2 = '0;
    endtask

    task automatic wait_ready(input string name, input int expect_cycles);
        int n = 0;
        while (!bus.ready && n < 40) begin
            n++;
            step();
        end
        chk(name, n, expect_cycles);
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned pc;
        idle();
        step();

        // Reset values, read ports active with nonzero addresses.
        bus.ren = 2'b11; bus.ars1 = 4'd3; bus.ars2 = 4'd9;
        do_reset();
        #1;
        chk("rst_ready",  {31'b0, bus.ready},  32'h0);
        chk("rst_hazard", {31'b0, bus.hazard}, 32'h0);
        chk("rst_cnt",    {27'b0, bus.pend_cnt}, 32'h0);
        chk("rst_rs1",    bus.rs1, 32'h0);
        chk("rst_rs2",    bus.rs2, 32'h0);
        wait_ready("clear_len0", 16);

        // Preload, then clear and confirm everything reads zero.
        idle();
        for (int i = 1; i < NREG; i++) begin
            bus.wen = 1; bus.waddr = 4'(i); bus.wdata = 32'hA500_0000 + 32'(i);
            step();
        end
        idle();
        bus.ren = 2'b01; bus.ars1 = 4'd12;
        #1;
        chk("preload_x12", bus.rs1, 32'hA500_000C);
        bus.rsv_en = 1; bus.rsv_addr = 4'd2;
        step();
        bus.rsv_en = 0;
        do_reset();
        wait_ready("clear_len1", 16);
        chk("clear_cnt", {27'b0, bus.pend_cnt}, 32'h0);
        for (int i = 1; i < NREG; i++) begin
            bus.ren = 2'b11; bus.ars1 = 4'(i); bus.ars2 = 4'(NREG - i);
            #1;
            chk("clear_rd", bus.rs1, 32'h0);
        end
        idle();
        step();

        // Forwarding.
        bus.wen = 1; bus.waddr = 4'd5; bus.wdata = 32'hDEADBEEF;
        bus.ren = 2'b11; bus.ars1 = 4'd5; bus.ars2 = 4'd5;
        #1;
        chk("fwd_rs1", bus.rs1, 32'hDEADBEEF);
        chk("fwd_rs2", bus.rs2, 32'hDEADBEEF);
        step();
        bus.wen = 0;
        #1;
        chk("stor_rs1", bus.rs1, 32'hDEADBEEF);
        chk("stor_rs2", bus.rs2, 32'hDEADBEEF);
        step();

        // x0 handling.
        idle();
        bus.wen = 1; bus.waddr = 4'd0; bus.wdata = 32'h1234;
        bus.ren = 2'b01; bus.ars1 = 4'd0;
        #1;
        chk("x0_rs1", bus.rs1, 32'h0);
        step();
        idle();
        pc = bus.pend_cnt;
        bus.rsv_en = 1; bus.rsv_addr = 4'd0;
        step();
        bus.rsv_en = 0;
        bus.ren = 2'b10; bus.ars2 = 4'd0;
        #1;
        chk("x0_rsv_cnt", {27'b0, bus.pend_cnt}, pc);
        chk("x0_hazard",  {31'b0, bus.hazard}, 32'h0);
        step();

        // Scoreboard: reserve x7, write back at t+3.
        idle();
        bus.rsv_en = 1; bus.rsv_addr = 4'd7;
        step();
        idle();
        bus.ren = 2'b01; bus.ars1 = 4'd7;
        #1;
        chk("sb_cnt1",  {27'b0, bus.pend_cnt}, 32'h1);
        chk("sb_haz1",  {31'b0, bus.hazard},   32'h1);
        step();
        step();
        bus.wen = 1; bus.waddr = 4'd7; bus.wdata = 32'h55;
        #1;
        chk("sb_haz_wb", {31'b0, bus.hazard}, 32'h0);
        chk("sb_rs1_wb", bus.rs1, 32'h55);
        step();
        bus.wen = 0;
        #1;
        chk("sb_cnt0", {27'b0, bus.pend_cnt}, 32'h0);
        chk("sb_rs1",  bus.rs1, 32'h55);

        // Write and reserve same address: reservation wins.
        idle();
        bus.rsv_en = 1; bus.rsv_addr = 4'd3;
        step();
        bus.wen = 1; bus.waddr = 4'd3; bus.wdata = 32'h33;
        step();
        idle();
        bus.ren = 2'b01; bus.ars1 = 4'd3;
        #1;
        chk("same_cnt", {27'b0, bus.pend_cnt}, 32'h1);
        chk("same_haz", {31'b0, bus.hazard},   32'h1);
        bus.wen = 1; bus.waddr = 4'd3; bus.wdata = 32'h34;
        step();

        // Write-back x4 and reserve x9 together.
        idle();
        bus.rsv_en = 1; bus.rsv_addr = 4'd4;
        step();
        bus.rsv_en = 1; bus.rsv_addr = 4'd9;
        bus.wen = 1; bus.waddr = 4'd4; bus.wdata = 32'h44;
        bus.ren = 2'b01; bus.ars1 = 4'd9;
        #1;
        chk("pair_haz_same", {31'b0, bus.hazard}, 32'h0);
        step();
        idle();
        bus.ren = 2'b11; bus.ars1 = 4'd9; bus.ars2 = 4'd4;
        #1;
        chk("pair_cnt",  {27'b0, bus.pend_cnt}, 32'h1);
        chk("pair_haz",  {31'b0, bus.hazard},   32'h1);
        bus.ren = 2'b10;
        #1;
        chk("pair_x4_free", {31'b0, bus.hazard}, 32'h0);
        chk("pair_x4_rd",   bus.rs2, 32'h44);
        step();

        // Reset with pending state, restart mid-sweep, traffic during CLEAR.
        idle();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.wen = 1; bus.waddr = 4'(i + 1); bus.wdata = 32'hBAD0_0000 + 32'(i);
            bus.rsv_en = 1; bus.rsv_addr = 4'(i + 8);
            step();
        end
        do_reset();
        wait_ready("clear_len_mid", 16);
        idle();
        chk("mid_cnt", {27'b0, bus.pend_cnt}, 32'h0);
        for (int i = 1; i < NREG; i++) begin
            bus.ren = 2'b01; bus.ars1 = 4'(i);
            #1;
            chk("mid_rd", bus.rs1, 32'h0);
            chk("mid_haz", {31'b0, bus.hazard}, 32'h0);
        end
        idle();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
